// File: rtl/btn_input.sv
// Button/switch input block: 2-flop synchronizer, per-bit debounce and sticky W1C press/release flags.
// Optional macro BTN_IRQ_EN adds a registered event interrupt; without it irq is tied to 0.
module btn_input #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] press_pend,
  output logic [WIDTH-1:0] rel_pend,
  input  logic [WIDTH-1:0] clr_press,
  input  logic [WIDTH-1:0] clr_rel,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] diff, upd, press_nxt, rel_nxt;

  // upd marks bits whose new level has been stable long enough to be accepted this edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    diff = s2 ^ btn;
    upd  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = diff[i] && (cnt[i] == CNT_LAST);
    end
    // Set terms are OR-ed after the clear mask, so a coincident set wins.
    press_nxt = (press_pend & ~clr_press) | (upd & s2);
    rel_nxt   = (rel_pend   & ~clr_rel)   | (upd & ~s2);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      btn        <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      // NOTE: the counter array is reset explicitly; a partial count must not survive reset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1         <= btn_in;
      s2         <= s1;
      btn        <= btn ^ upd;
      press_pend <= press_nxt;
      rel_pend   <= rel_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BTN_IRQ_EN
  // Registered from the next-state flags so irq tracks press_pend/rel_pend on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(press_nxt | rel_nxt);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
